y_reg_arbiter: RTL and testbench
================================

Name: y_reg_arbiter

Overview:
- Arbitrates ownership of the shared 16-bit Y operand register between N_REQ datapath requesters (ALU sequencer, load unit, debug port, ...).
- Grants exclusive ownership with round-robin fairness.
- Steers the owner's write data and enable onto the Y register's en/in inputs.
- Sits between the control-unit requesters and the Y register instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, data width of the Y register.
- TIMEOUT_CYC, 15, idle-owner cycles before a forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester ownership request, level.
- rel  input  N_REQ  per-requester release pulse.
- wr  input  N_REQ  per-requester write strobe.
- wr_data  input  N_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant, registered.
- busy  output  1  high while any requester owns Y.
- owner_id  output  clog2(N_REQ)  index of the current owner; 0 when idle.
- y_en  output  1  enable to the Y register.
- y_in  output  WIDTH  data to the Y register.
- wr_err  output  1  one-cycle pulse when a non-owner asserts wr.
- to_pulse  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE, gnt=0, busy=0, owner_id=0, rr_ptr=0, wr_err=0, to_pulse=0, timeout counter=0.
  - y_en=0, y_in=0.
  - Reset mid-ownership drops gnt immediately; no write is issued.
- States: IDLE, OWN.
- IDLE:
  - If req is nonzero, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... mod N_REQ).
  - Next edge: state=OWN, gnt[sel]=1, owner_id=sel, busy=1.
  - Latency from req to gnt is 1 cycle.
  - If req is zero, stay in IDLE.
- OWN:
  - y_en = wr[owner] (combinational); y_in = wr_data slice of the owner. Both are 0 when not writing.
  - Y captures the value on the edge after the strobe.
  - The req inputs are ignored while in OWN.
  - rel[owner]=1: next edge state=IDLE, gnt=0, busy=0, owner_id=0, rr_ptr=(owner+1) mod N_REQ.
  - wr and rel asserted in the same cycle: the write is still performed.
  - rel from a non-owner is ignored.
  - A new grant needs at least 1 IDLE cycle after a release (1-cycle bubble between owners).
- Violations:
  - wr[j]=1 with j not the owner, or any wr while IDLE, does not affect y_en.
  - wr_err pulses high for 1 cycle on the following edge.
  - Multiple violators in one cycle produce a single pulse.
- Fairness: the requester just released has the lowest priority in the next arbitration.
- y_en is never asserted while in IDLE.

Optional Feature:
- Macro: Y_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on grant and on every owner write.
  - It increments each OWN cycle without an owner write.
  - When it reaches TIMEOUT_CYC, the next edge forces a release exactly as rel[owner] would, including the rr_ptr advance.
  - to_pulse is high for that 1 cycle.
  - An owner rel in the same cycle as the timeout counts as a normal release; to_pulse stays 0.
- Without the macro: no counter logic, to_pulse is tied to 0, and ownership lasts until rel.

Test Plan:
- Reset release, then req=4'b0010 -> gnt=4'b0010, owner_id=1, busy=1 on the 1st edge after req; all outputs 0 during reset.
- Owner 1 writes: wr[1]=1, data=16'hA5C3 -> y_en=1, y_in=16'hA5C3 in the same cycle. Then rel[1] -> gnt=0 next edge, rr_ptr=2.
- req=4'b0101 held from reset -> grant order 0, 2, 0, 2 across successive releases, with a 1-cycle idle bubble between grants.
- Owner 0, requester 3 pulses wr[3] with 16'hFFFF -> y_en=0, wr_err=1 for exactly 1 cycle, Y unchanged.
- Y_ARB_TIMEOUT_EN with TIMEOUT_CYC=15: owner 2 idles for 15 cycles -> to_pulse=1, gnt=0, rr_ptr=3. Repeat with a write at cycle 10 -> no timeout until 15 idle cycles after that write.
- rst_b dropped while owner 1 has wr asserted -> gnt=0, y_en=0 immediately (async). After release, rr_ptr=0, so with req=4'b1111 the first grant goes to requester 0.

Source files
------------

// File: rtl/y_reg_arbiter.sv
// y_reg_arbiter: round-robin ownership arbiter for the shared Y operand register.
// Grants one requester at a time, steers the owner's write strobe and data onto
// the Y register en/in pins, and flags writes from anyone who is not the owner.
// Optional feature: define Y_ARB_TIMEOUT_EN to force a release after TIMEOUT_CYC
// consecutive owner cycles without a write (reported on to_pulse).
module y_reg_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         rel,
    input  logic [N_REQ-1:0]         wr,
    input  logic [N_REQ*WIDTH-1:0]   wr_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     y_en,
    output logic [WIDTH-1:0]         y_in,
    output logic                     wr_err,
    output logic                     to_pulse
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             wr_err_q, wr_err_d;

    logic             arb_found;
    logic [IW-1:0]    arb_sel;
    int               arb_idx;
    logic             owner_wr;
    logic             owner_rel;
    logic             timeout_hit;
    logic [IW-1:0]    owner_nxt;

    // Only the current owner can drive Y; everything else is masked to zero.
    assign owner_wr  = (state_q == OWN) && wr[owner_q];
    assign owner_rel = (state_q == OWN) && rel[owner_q];
    assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    assign y_en     = owner_wr;
    assign y_in     = owner_wr ? wr_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
    assign gnt      = gnt_q;
    assign busy     = (state_q == OWN);
    assign owner_id = owner_q;
    assign wr_err   = wr_err_q;

    // Round-robin pick: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = IW'(arb_idx);
            end
        end
    end

`ifdef Y_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_pulse_q, to_pulse_d;

    // Fires on the owner cycle that would complete TIMEOUT_CYC idle cycles.
    assign timeout_hit = (state_q == OWN) && !owner_wr && (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign to_pulse    = to_pulse_q;

    // Idle-owner counter: cleared on grant and owner writes, counts otherwise.
    always_comb begin
        cnt_d      = cnt_q;
        to_pulse_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (owner_rel) begin
            cnt_d = '0;
        end else if (timeout_hit) begin
            cnt_d      = '0;
            to_pulse_d = 1'b1;
        end else if (owner_wr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter and pulse registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q      <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            to_pulse_q <= to_pulse_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_pulse    = 1'b0;
`endif

    // Next-state: grant from IDLE, release on owner rel or forced timeout.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wr_err_d = |(wr & ~gnt_q);
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d          = OWN;
                    gnt_d            = '0;
                    gnt_d[arb_sel]   = 1'b1;
                    owner_d          = arb_sel;
                end
            end
            OWN: begin
                if (owner_rel || timeout_hit) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    owner_d  = '0;
                    rr_ptr_d = owner_nxt;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wr_err_q <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_y_reg_arbiter.sv
// tb_y_reg_arbiter: scoreboard bench for y_reg_arbiter (N_REQ=4, WIDTH=16).
// Expected registered outputs are queued when a cycle's stimulus is driven and
// popped after the clock edge. A local Y register follows y_en/y_in.
module tb_y_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 15;

    logic           clk;
    logic           rst_b;
    logic [N-1:0]   req, rel, wr;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [1:0]     owner_id;
    logic           y_en;
    logic [W-1:0]   y_in;
    logic           wr_err;
    logic           to_pulse;

    y_reg_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .rel(rel), .wr(wr),
        .wr_data(wr_data), .gnt(gnt), .busy(busy), .owner_id(owner_id),
        .y_en(y_en), .y_in(y_in), .wr_err(wr_err), .to_pulse(to_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the Y register the arbiter feeds.
    logic [W-1:0] y_q = '0;
    always @(posedge clk) if (y_en) y_q <= y_in;

    typedef struct {
        logic [N-1:0] gnt;
        logic         busy;
        logic [1:0]   oid;
        logic         werr;
        logic         to;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    logic         m_own;
    int           m_owner;
    int           m_rr;
    int           m_cnt;
    logic [W-1:0] m_y = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    // One clock cycle: drive, check combinational steering, queue the
    // expected registered outputs, clock, then pop and compare.
    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] rl,
                         input logic [N-1:0] w, input logic [N*W-1:0] d);
        exp_t         e;
        logic         ey;
        logic [W-1:0] eyin;
        int           sel;
        logic         relo, tmo;
        req = rq; rel = rl; wr = w; wr_data = d;
        #1;
        ey   = m_own && w[m_owner];
        eyin = ey ? d[m_owner*W +: W] : '0;
        chk("y_en", y_en, ey);
        chk("y_in", y_in, eyin);
        e.werr = |(w & ~(m_own ? (4'b0001 << m_owner) : 4'b0000));
        e.to   = 1'b0;
        if (!m_own) begin
            if (rq != '0) begin
                sel = m_rr;
                for (int k = 0; k < N; k++) begin
                    if (rq[(m_rr + k) % N]) begin
                        sel = (m_rr + k) % N;
                        break;
                    end
                end
                m_own   = 1'b1;
                m_owner = sel;
                m_cnt   = 0;
            end
        end else begin
            relo = rl[m_owner];
            tmo  = 1'b0;
`ifdef Y_ARB_TIMEOUT_EN
            tmo = !ey && (m_cnt == TO - 1);
`endif
            if (relo || tmo) begin
                m_own = 1'b0;
                m_rr  = (m_owner + 1) % N;
                e.to  = tmo && !relo;
            end else begin
                m_cnt = ey ? 0 : m_cnt + 1;
            end
        end
        if (ey) m_y = eyin;
        e.gnt  = m_own ? (4'b0001 << m_owner) : 4'b0000;
        e.busy = m_own;
        e.oid  = m_own ? 2'(m_owner) : 2'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("busy", busy, e.busy);
        chk("owner_id", owner_id, e.oid);
        chk("wr_err", wr_err, e.werr);
        chk("to_pulse", to_pulse, e.to);
        chk("y_reg", y_q, m_y);
    endtask

    task automatic do_reset();
        req = '0; rel = '0; wr = '0; wr_data = '0;
        rst_b = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oid", owner_id, 0);
        chk("rst_yen", y_en, 0);
        chk("rst_werr", wr_err, 0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    function automatic logic [N*W-1:0] slot(input int i, input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[i*W +: W] = v;
        return r;
    endfunction

    int order[4];
    int exp_order[4];

    initial begin
        rst_b = 1'b0;
        req = 4'b0010; rel = '0; wr = 4'b0010; wr_data = slot(1, 16'h1234);
        model_reset();
        // outputs held at zero across an edge while in reset
        @(posedge clk); #1;
        chk("rst_hold_gnt", gnt, 0);
        chk("rst_hold_busy", busy, 0);
        chk("rst_hold_yen", y_en, 0);
        chk("rst_hold_yin", y_in, 0);
        chk("rst_hold_to", to_pulse, 0);
        do_reset();

        // single grant to requester 1, write, release
        cycle(4'b0010, 4'b0000, 4'b0000, '0);
        chk("t1_gnt", gnt, 4'b0010);
        chk("t1_oid", owner_id, 1);
        req = 4'b0010; wr = 4'b0010; wr_data = slot(1, 16'hA5C3);
        #1;
        chk("t2_yen", y_en, 1);
        chk("t2_yin", y_in, 16'hA5C3);
        cycle(4'b0010, 4'b0000, 4'b0010, slot(1, 16'hA5C3));
        chk("t2_yreg", y_q, 16'hA5C3);
        cycle(4'b0000, 4'b0010, 4'b0000, '0);
        chk("t2_rel_gnt", gnt, 0);
        // rr_ptr now 2: requester 2 wins over 1 and 3
        cycle(4'b1110, 4'b0000, 4'b0000, '0);
        chk("t2_rr_gnt", gnt, 4'b0100);
        cycle(4'b0000, 4'b0100, 4'b0000, '0);

        // fairness: req=0101 held, grants alternate with an idle bubble
        do_reset();
        exp_order = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0101, 4'b0000, 4'b0000, '0);
            order[i] = int'(owner_id);
            chk("rr_order", order[i], exp_order[i]);
            cycle(4'b0101, 4'b0001 << order[i], 4'b0000, '0);
            chk("rr_bubble", busy, 0);
        end

        // non-owner write: owner 0, requester 3 strobes FFFF
        do_reset();
        cycle(4'b0001, 4'b0000, 4'b0000, '0);
        cycle(4'b0000, 4'b0000, 4'b0001, slot(0, 16'h0F0F));
        cycle(4'b0000, 4'b0000, 4'b1000, slot(3, 16'hFFFF));
        chk("viol_werr", wr_err, 1);
        chk("viol_y", y_q, 16'h0F0F);
        cycle(4'b0000, 4'b0000, 4'b0000, '0);
        chk("viol_werr_clr", wr_err, 0);
        // several violators plus owner write in one cycle
        cycle(4'b0000, 4'b0000, 4'b1111, slot(0, 16'h7777) | slot(2, 16'h2222));
        chk("multi_y", y_q, 16'h7777);
        // non-owner release is ignored
        cycle(4'b0000, 4'b1110, 4'b0000, '0);
        chk("nonowner_rel", gnt, 4'b0001);
        // write and release together still writes
        cycle(4'b0000, 4'b0001, 4'b0001, slot(0, 16'hBEEF));
        chk("wr_rel_y", y_q, 16'hBEEF);
        chk("wr_rel_gnt", gnt, 0);
        // write while idle
        cycle(4'b0000, 4'b0000, 4'b0100, slot(2, 16'h1111));
        chk("idle_werr", wr_err, 1);

`ifdef Y_ARB_TIMEOUT_EN
        // owner 2 idles TO cycles -> forced release
        do_reset();
        cycle(4'b0100, 4'b0000, 4'b0000, '0);
        for (int i = 0; i < TO; i++) cycle(4'b0000, 4'b0000, 4'b0000, '0);
        chk("to_fire", to_pulse, 1);
        chk("to_gnt", gnt, 0);
        cycle(4'b1111, 4'b0000, 4'b0000, '0);
        chk("to_rr", owner_id, 3);
        cycle(4'b0000, 4'b1000, 4'b0000, '0);
        // write at cycle 10 restarts the count
        cycle(4'b0100, 4'b0000, 4'b0000, '0);
        for (int i = 0; i < 9; i++) cycle(4'b0000, 4'b0000, 4'b0000, '0);
        cycle(4'b0000, 4'b0000, 4'b0100, slot(2, 16'hC0DE));
        for (int i = 0; i < TO - 1; i++) cycle(4'b0000, 4'b0000, 4'b0000, '0);
        chk("to_late", gnt, 4'b0100);
        cycle(4'b0000, 4'b0000, 4'b0000, '0);
        chk("to_late_fire", to_pulse, 1);
`endif

        // async reset while owner 1 writes
        do_reset();
        cycle(4'b0010, 4'b0000, 4'b0000, '0);
        wr = 4'b0010; wr_data = slot(1, 16'h5555);
        #1;
        chk("ar_yen_pre", y_en, 1);
        rst_b = 1'b0;
        #1;
        chk("ar_gnt", gnt, 0);
        chk("ar_yen", y_en, 0);
        chk("ar_busy", busy, 0);
        wr = '0; req = '0;
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        cycle(4'b1111, 4'b0000, 4'b0000, '0);
        chk("ar_first", gnt, 4'b0001);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r_rel;
            r_rel = ($urandom_range(0, 3) == 0) ? 4'(1 << (m_owner % N)) : 4'(($urandom_range(0, 7) == 0) ? $urandom : 0);
            cycle(4'($urandom), r_rel, ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                  {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
